// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned divider, radix-2 restoring, one
// quotient bit per clock.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request pulse, sampled only while idle
//   dividend     unsigned dividend, captured with start
//   divisor      unsigned divisor, captured with start
//   busy         high while an operation is running or completing
//   done         one-cycle pulse, results valid from this cycle
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  registered zero-divisor flag of the last completed operation
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  // Working remainder keeps only WIDTH bits: after each restore step it is
  // below the divisor, so its top bit is always zero and only needs to exist
  // inside the shifted trial value.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  // One restoring step: shift {R,Q} left, trial-subtract over WIDTH+1 bits.
  always_comb begin
    w_shift = {r_rem, r_q[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_dvsr};
  end

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_dvsr  <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvsr  <= divisor;
            r_rem   <= '0;
            r_q     <= dividend;
            r_zero  <= (divisor == '0);
            // A zero divisor skips the iterations and completes next edge.
            r_cnt   <= (divisor == '0) ? '0 : CW'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            // Final cycle: publish results and enter DONE.
            if (r_zero) begin
              r_quot <= '1;
              r_remo <= r_q;
              r_dbz  <= 1'b1;
            end else begin
              r_quot <= r_q;
              r_remo <= r_rem;
              r_dbz  <= 1'b0;
            end
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (!w_trial[WIDTH]) begin
              r_rem <= w_trial[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int unsigned  t;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_quotient"}, 32'(quotient), 32'(e.q));
        chk({e.tag, "_remainder"}, 32'(remainder), 32'(e.r));
        chk({e.tag, "_div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
        chk({e.tag, "_done_cycle"}, cyc, e.t);
        chk({e.tag, "_busy_at_done"}, 32'(busy), 32'd1);
        chk({e.tag, "_done_pulse"}, 32'(prev_done), 32'd0);
      end
    end
    prev_done <= done;
  end

  // Drive one request; optionally record its expected completion.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_done, input string tag);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (expect_done) begin
      e.q   = (b == '0) ? '1 : W'(a / b);
      e.r   = (b == '0) ? a : W'(a % b);
      e.dbz = (b == '0);
      e.t   = cyc + 1 + ((b == '0) ? 1 : W + 1);
      e.tag = tag;
      sb.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    // Operands wander while busy; the captured values must be used.
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle", tag);
    end
  endtask

  initial begin
    int n;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_quotient", 32'(quotient), 0);
    chk("rst_remainder", 32'(remainder), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);

    // Basic 200/7 with busy window length
    issue(8'd200, 8'd7, 1'b1, "basic");
    n = 0;
    while (busy && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("basic_busy_cycles", 32'(n), 32'd10);
    wait_idle("basic");
    chk("hold_quotient", 32'(quotient), 32'd28);
    chk("hold_remainder", 32'(remainder), 32'd4);

    // Boundaries
    issue(8'd255, 8'd1, 1'b1, "b255_1");     wait_idle("b255_1");
    issue(8'd255, 8'd255, 1'b1, "b255_255"); wait_idle("b255_255");
    issue(8'd5, 8'd9, 1'b1, "b5_9");         wait_idle("b5_9");
    issue(8'd0, 8'd3, 1'b1, "b0_3");         wait_idle("b0_3");

    // Divide by zero, then a normal op clears the flag
    issue(8'd100, 8'd0, 1'b1, "dbz");        wait_idle("dbz");
    issue(8'd9, 8'd3, 1'b1, "after_dbz");
    repeat (3) @(negedge clk);
    chk("hold_dbz_during_run", 32'(div_by_zero), 32'd1);
    chk("hold_q_during_run", 32'(quotient), 32'd255);
    wait_idle("after_dbz");

    // Start while busy is ignored; start in the cycle after done is taken
    issue(8'd200, 8'd7, 1'b1, "busy_ign");
    repeat (2) @(negedge clk);
    dividend = 8'd10;
    divisor  = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    n = 0;
    while (!done && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("busy_ign_done_seen", 32'(done), 32'd1);
    issue(8'd45, 8'd6, 1'b1, "back_to_back");
    wait_idle("back_to_back");

    // Reset mid-operation abandons the op
    issue(8'd200, 8'd7, 1'b0, "abort");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_quotient", 32'(quotient), 0);
    chk("abort_remainder", 32'(remainder), 0);
    chk("abort_dbz", 32'(div_by_zero), 0);
    repeat (15) @(negedge clk);
    chk("abort_idle", 32'(busy), 0);
    issue(8'd50, 8'd6, 1'b1, "post_abort");
    wait_idle("post_abort");

    // Random operand pairs against the integer model
    for (int i = 0; i < 200; i++) begin
      a = W'($urandom);
      b = W'($urandom_range(0, 255));
      issue(a, b, 1'b1, "rand");
      wait_idle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
